// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: format select codes and widths.
// Used by the combinational decoder and by the registered pipeline stage.
package imm_pkg;

    localparam int IMM_SRC_W = 3;

    localparam logic [IMM_SRC_W-1:0] IMM_I   = 3'd0;
    localparam logic [IMM_SRC_W-1:0] IMM_S   = 3'd1;
    localparam logic [IMM_SRC_W-1:0] IMM_B   = 3'd2;
    localparam logic [IMM_SRC_W-1:0] IMM_J   = 3'd3;
    localparam logic [IMM_SRC_W-1:0] IMM_U   = 3'd4;
    localparam logic [IMM_SRC_W-1:0] IMM_Z   = 3'd5;
    localparam logic [IMM_SRC_W-1:0] IMM_SH  = 3'd6;
    localparam logic [IMM_SRC_W-1:0] IMM_RSV = 3'd7;

endpackage

// File: rtl/imm_gen_stage_imm_decode.sv
// Purely combinational immediate extraction and extension to XLEN.
// Shared with the single-cycle core, so it carries no state.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]          instr,
    input  logic [IMM_SRC_W-1:0] imm_src,
    output logic [XLEN-1:0]      imm,
    output logic                 illegal
);

    // Format select: signed casts sign-extend, unsigned casts zero-extend.
    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (imm_src)
            IMM_I:  imm = XLEN'($signed(instr[31:20]));
            IMM_S:  imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B:  imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                         instr[11:8], 1'b0}));
            IMM_J:  imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                         instr[30:21], 1'b0}));
            IMM_U:  imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_Z:  imm = XLEN'(instr[19:15]);
            IMM_SH: begin
                if (XLEN == 64) begin
                    imm = XLEN'(instr[25:20]);
                end else begin
                    imm = XLEN'(instr[24:20]);
                end
            end
            IMM_RSV: begin
                imm     = '0;
                illegal = 1'b1;
            end
            default: begin
                imm     = '0;
                illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator stage with a 2-entry skid buffer.
// in_ready comes straight from a flop so out_ready never reaches it combinationally.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [IMM_SRC_W-1:0] in_imm_src,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_illegal
);

    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;
    logic             accept;
    logic             advance;

    logic             out_valid_q,   out_valid_d;
    logic [XLEN-1:0]  out_imm_q,     out_imm_d;
    logic [TAG_W-1:0] out_tag_q,     out_tag_d;
    logic             out_illegal_q, out_illegal_d;
    logic             skid_valid_q,   skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q,     skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q,     skid_tag_d;
    logic             skid_illegal_q, skid_illegal_d;
    logic             in_ready_q,     in_ready_d;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .imm_src (in_imm_src),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign accept  = in_valid & in_ready_q;
    assign advance = ~out_valid_q | out_ready;

    // Next-state: output slot refills from skid first to keep FIFO order.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_imm_d      = out_imm_q;
        out_tag_d      = out_tag_q;
        out_illegal_d  = out_illegal_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_tag_d     = skid_tag_q;
        skid_illegal_d = skid_illegal_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (advance) begin
            if (skid_valid_q) begin
                out_valid_d   = 1'b1;
                out_imm_d     = skid_imm_q;
                out_tag_d     = skid_tag_q;
                out_illegal_d = skid_illegal_q;
                skid_valid_d  = accept;
                if (accept) begin
                    skid_imm_d     = dec_imm;
                    skid_tag_d     = in_tag;
                    skid_illegal_d = dec_illegal;
                end else begin
                    skid_imm_d     = skid_imm_q;
                end
            end else if (accept) begin
                out_valid_d   = 1'b1;
                out_imm_d     = dec_imm;
                out_tag_d     = in_tag;
                out_illegal_d = dec_illegal;
            end else begin
                out_valid_d   = 1'b0;
            end
        end else begin
            if (accept) begin
                skid_valid_d   = 1'b1;
                skid_imm_d     = dec_imm;
                skid_tag_d     = in_tag;
                skid_illegal_d = dec_illegal;
            end else begin
                skid_valid_d   = skid_valid_q;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    // State registers with asynchronous reset to an empty, ready stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_imm_q      <= '0;
            out_tag_q      <= '0;
            out_illegal_q  <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_tag_q     <= '0;
            skid_illegal_q <= 1'b0;
            in_ready_q     <= 1'b1;
        end else begin
            out_valid_q    <= out_valid_d;
            out_imm_q      <= out_imm_d;
            out_tag_q      <= out_tag_d;
            out_illegal_q  <= out_illegal_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_tag_q     <= skid_tag_d;
            skid_illegal_q <= skid_illegal_d;
            in_ready_q     <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench: XLEN=32 and XLEN=64 instances share one stimulus stream;
// expectations come from an arithmetic model of the immediate formats.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic [2:0]  in_imm_src = 3'd0;
    logic [7:0]  in_tag = 8'd0;

    logic        in_ready32, in_ready64, out_valid32, out_valid64, ill32, ill64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [7:0]  tag32, tag64;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(imm32),
        .out_tag(tag32), .out_illegal(ill32));

    imm_gen_stage #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(imm64),
        .out_tag(tag64), .out_illegal(ill64));

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        ill;
    } exp_t;

    exp_t        sb [2][$];
    logic        ov [2];
    logic        ir [2];
    logic [63:0] oimm [2];
    logic [7:0]  otag [2];
    logic        oill [2];

    assign ov[0] = out_valid32;       assign ov[1] = out_valid64;
    assign ir[0] = in_ready32;        assign ir[1] = in_ready64;
    assign oimm[0] = {32'd0, imm32};  assign oimm[1] = imm64;
    assign otag[0] = tag32;           assign otag[1] = tag64;
    assign oill[0] = ill32;           assign oill[1] = ill64;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: assemble each field as an integer, then sign-correct arithmetically.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                             input int xlen);
        longint v;
        case (src)
            3'd0: begin v = longint'(ins[31:20]); if (v >= 2048) v -= 4096; end
            3'd1: begin v = longint'({ins[31:25], ins[11:7]}); if (v >= 2048) v -= 4096; end
            3'd2: begin
                v = 2 * longint'({ins[31], ins[7], ins[30:25], ins[11:8]});
                if (v >= 4096) v -= 8192;
            end
            3'd3: begin
                v = 2 * longint'({ins[31], ins[19:12], ins[20], ins[30:21]});
                if (v >= 1048576) v -= 2097152;
            end
            3'd4: begin
                v = longint'(ins[31:12]) * 4096;
                if (v >= 64'sd2147483648) v -= 64'sd4294967296;
            end
            3'd5: v = longint'(ins[19:15]);
            3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'd0, v[31:0]};
        return v;
    endfunction

    // One cycle of stimulus; expectations are pushed for every accepted entry.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [2:0] src,
                        input logic [7:0] tag, input logic ordy, input logic fl,
                        input bit use_c, input logic [63:0] c32, input logic [63:0] c64,
                        output bit acc);
        exp_t e;
        in_valid = iv; in_instr = ins; in_imm_src = src; in_tag = tag;
        out_ready = ordy; flush = fl;
        if (iv && !fl) begin
            for (int d = 0; d < 2; d++) begin
                e.tag = tag;
                e.ill = (src == 3'd7);
                if (use_c) e.imm = (d == 0) ? c32 : c64;
                else       e.imm = ref_imm(ins, src, (d == 0) ? 32 : 64);
                if (ir[d]) sb[d].push_back(e);
            end
        end
        acc = iv && !fl && in_ready32;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, a);
    endtask

    // Monitor: pops and compares on each output handshake, checks stall stability and flush.
    logic        stall_prev [2];
    logic [63:0] hold_imm [2];
    logic [7:0]  hold_tag [2];
    logic        hold_ill [2];
    logic        flush_prev;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev[0] = 1'b0; stall_prev[1] = 1'b0; flush_prev = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (flush_prev) begin
                    chk("flush_out_valid", {63'd0, ov[d]}, 64'd0);
                    chk("flush_in_ready", {63'd0, ir[d]}, 64'd1);
                end
                if (stall_prev[d] && ov[d]) begin
                    chk("stall_imm", oimm[d], hold_imm[d]);
                    chk("stall_tag", {56'd0, otag[d]}, {56'd0, hold_tag[d]});
                    chk("stall_ill", {63'd0, oill[d]}, {63'd0, hold_ill[d]});
                end
                if (ov[d] && out_ready) begin
                    if (sb[d].size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_output dut=%0d tag=%0h expected=none", d, otag[d]);
                    end else begin
                        e = sb[d].pop_front();
                        chk("out_imm", oimm[d], e.imm);
                        chk("out_tag", {56'd0, otag[d]}, {56'd0, e.tag});
                        chk("out_illegal", {63'd0, oill[d]}, {63'd0, e.ill});
                    end
                end
                stall_prev[d] = ov[d] && !out_ready && !flush;
                hold_imm[d] = oimm[d]; hold_tag[d] = otag[d]; hold_ill[d] = oill[d];
                if (flush) sb[d].delete();
            end
            flush_prev = flush;
        end
    end

    logic [31:0] dv_ins [6] = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7,
                                32'h800000B7, 32'h03F09093, 32'h03F09093};
    logic [2:0]  dv_src [6] = '{3'd0, 3'd2, 3'd4, 3'd4, 3'd6, 3'd7};
    logic [63:0] dv_e32 [6] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'h12345000,
                                64'h80000000, 64'd31, 64'd0};
    logic [63:0] dv_e64 [6] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h12345000,
                                64'hFFFFFFFF80000000, 64'd63, 64'd0};

    initial begin
        bit acc;
        int t, budget;
        logic [7:0] tg;

        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", {63'd0, ov[d]}, 64'd0);
            chk("rst_in_ready", {63'd0, ir[d]}, 64'd1);
            chk("rst_out_imm", oimm[d], 64'd0);
            chk("rst_out_tag", {56'd0, otag[d]}, 64'd0);
            chk("rst_out_illegal", {63'd0, oill[d]}, 64'd0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Directed formats with spec-given values.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, dv_ins[i], dv_src[i], 8'(i + 100), 1'b1, 1'b0, 1'b1, dv_e32[i], dv_e64[i], acc);
            chk("latency_out_valid32", {63'd0, out_valid32}, 64'd1);
            chk("latency_out_valid64", {63'd0, out_valid64}, 64'd1);
            idle(1);
        end

        // Backpressure: tags 1..4 with the output stalled for a while.
        t = 1; budget = 0;
        while (t <= 4 && budget < 30) begin
            step(1'b1, $urandom, 3'($urandom_range(0, 6)), 8'(t), (budget >= 6), 1'b0,
                 1'b0, 64'd0, 64'd0, acc);
            if (acc) t++;
            budget++;
            if (budget == 2) begin
                chk("bp_in_ready32", {63'd0, in_ready32}, 64'd0);
                chk("bp_in_ready64", {63'd0, in_ready64}, 64'd0);
                chk("bp_out_tag", {56'd0, tag32}, 64'd1);
            end
        end
        chk("bp_all_accepted", 64'(t), 64'd5);
        idle(4);

        // Flush with output and skid full plus a new input in the same cycle.
        step(1'b1, $urandom, 3'd0, 8'd10, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, acc);
        step(1'b1, $urandom, 3'd1, 8'd11, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, acc);
        step(1'b1, $urandom, 3'd2, 8'd12, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, acc);
        chk("flush_now_valid", {63'd0, out_valid64}, 64'd0);
        chk("flush_now_ready", {63'd0, in_ready64}, 64'd1);
        idle(4);

        // Randomised traffic with occasional flushes.
        tg = 8'd20;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom, 3'($urandom_range(0, 7)), tg,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, 1'b0, 64'd0, 64'd0, acc);
            if (acc) tg++;
        end
        idle(6);
        chk("drain_empty32", 64'(sb[0].size()), 64'd0);
        chk("drain_empty64", 64'(sb[1].size()), 64'd0);

        // Asynchronous reset mid-stream, between edges.
        step(1'b1, $urandom, 3'd0, 8'd40, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, acc);
        step(1'b1, $urandom, 3'd0, 8'd41, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, acc);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'd0, out_valid32}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready32}, 64'd1);
        chk("arst_out_valid64", {63'd0, out_valid64}, 64'd0);
        sb[0].delete(); sb[1].delete();
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_imm_src = 3'd0; in_tag = 8'd77;
        out_ready = 1'b1; flush = 1'b0;
        @(negedge clk); rst = 1'b0;
        sb[0].push_back('{64'hFFFFFFFF, 8'd77, 1'b0});
        sb[1].push_back('{64'hFFFFFFFFFFFFFFFF, 8'd77, 1'b0});
        @(posedge clk); #1;
        chk("post_rst_out_valid", {63'd0, out_valid32}, 64'd1);
        idle(4);
        chk("final_empty32", 64'(sb[0].size()), 64'd0);
        chk("final_empty64", 64'(sb[1].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
